uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tick_gen.sv | 18 +
 rtl/uart_rx.sv | 134 +++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, oversample
// ratio and the 2-of-3 majority vote used for bit recovery.
package uart_pkg;

   localparam int OVERSAMPLE = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Turns each rising edge of a clk-domain square wave into a one-clk pulse.
module uart_tick_gen (
   input  logic clk,
   input  logic rst,
   input  logic bclk_x8,
   output logic tick
);

   logic bclk_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) bclk_q <= 1'b0;
      else     bclk_q <= bclk_x8;
   end

   assign tick = bclk_x8 & ~bclk_q;

endmodule

// File: rtl/uart_rx.sv
// 8x-oversampled UART receiver: 2-flop input synchronizer, majority vote of
// three mid-bit samples, LSB-first payload, stop-bit error flag.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bclk_x8,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int CNT_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [CNT_W-1:0] SMP_A    = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] SMP_B    = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] SMP_C    = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   logic                 tick;
   logic                 rx_s1, rx_s2;
   uart_state_t          state, state_n;
   logic [CNT_W-1:0]     cnt, cnt_n;
   logic [BIT_W-1:0]     bit_idx, bit_idx_n;
   logic [DATA_BITS-1:0] shreg, shreg_n;
   logic [2:0]           samp, samp_n;
   logic [DATA_BITS-1:0] data_n;
   logic                 frame_err_n, valid_n;
   logic                 bit_v;

   uart_tick_gen u_tick (
      .clk     (clk),
      .rst     (rst),
      .bclk_x8 (bclk_x8),
      .tick    (tick)
   );

   // Synchronizer resets to the idle line level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         samp      <= '0;
         data      <= '0;
         frame_err <= 1'b0;
         valid     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_idx   <= bit_idx_n;
         shreg     <= shreg_n;
         samp      <= samp_n;
         data      <= data_n;
         frame_err <= frame_err_n;
         valid     <= valid_n;
      end
   end

   assign bit_v = maj3(samp);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_idx_n   = bit_idx;
      shreg_n     = shreg;
      samp_n      = samp;
      data_n      = data;
      frame_err_n = frame_err;
      valid_n     = 1'b0;

      if (tick) begin
         if (state == IDLE) begin
            if (!rx_s2) begin
               state_n = START;
               cnt_n   = '0;
            end
         end else begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt == SMP_A) samp_n[0] = rx_s2;
            if (cnt == SMP_B) samp_n[1] = rx_s2;
            if (cnt == SMP_C) samp_n[2] = rx_s2;

            // Bit decision on the last sample slot; samples are all in by now.
            if (cnt == CNT_LAST) begin
               case (state)
                  START: begin
                     if (bit_v) begin
                        state_n = IDLE;
                     end else begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                     end
                  end
                  DATA: begin
                     shreg_n   = {bit_v, shreg[DATA_BITS-1:1]};
                     bit_idx_n = bit_idx + BIT_W'(1);
                     if (bit_idx == BIT_LAST) state_n = STOP;
                  end
                  STOP: begin
                     data_n      = shreg;
                     frame_err_n = ~bit_v;
                     valid_n     = 1'b1;
                     state_n     = IDLE;
                  end
                  default: state_n = IDLE;
               endcase
            end
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are built slot by slot on
// the line, the expected payload/error is queued, and a monitor checks each valid.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DB = 8;

   typedef struct {
      logic [7:0] d;
      logic       fe;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          bclk_x8;
   logic          rx;
   logic [DB-1:0] data;
   logic          valid, frame_err, busy;

   uart_rx #(.DATA_BITS(DB)) dut (
      .clk       (clk),
      .rst       (rst),
      .bclk_x8   (bclk_x8),
      .rx        (rx),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Baud reference: square wave of period bper clks, can be frozen.
   int   bper     = 109;
   int   bcnt     = 0;
   logic bclk_run = 1'b1;
   always @(posedge clk) if (bclk_run) bcnt <= (bcnt >= bper - 1) ? 0 : bcnt + 1;
   assign bclk_x8 = (bcnt >= bper / 2);

   int         errors   = 0;
   int         checks   = 0;
   int         n_pushed = 0;
   int         n_valid  = 0;
   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] last_exp = 8'h00;
   logic       prev_valid = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_valid <= 1'b0;
      end else begin
         if (valid) begin
            n_valid++;
            chk("valid_one_clk", 32'(prev_valid), 32'd0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: data %0h, no frame pending", data);
            end else begin
               mon_e = exp_q.pop_front();
               chk("data", 32'(data), 32'(mon_e.d));
               chk("frame_err", 32'(frame_err), 32'(mon_e.fe));
               last_exp = mon_e.d;
            end
         end
         prev_valid <= valid;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // One slot = one bclk_x8 period; the line changes on the falling edge so
   // the following tick sees a settled, synchronized value.
   task automatic wait_fall();
      logic pv;
      do begin
         pv = bclk_x8;
         @(posedge clk);
         #1;
      end while (!(pv && !bclk_x8));
   endtask

   task automatic drive_slot(input logic v);
      wait_fall();
      rx = v;
   endtask

   task automatic idle_slots(input int n);
      for (int i = 0; i < n; i++) drive_slot(1'b1);
   endtask

   // gmode: 0 clean, 1 invert slot 5 of every bit, 2 invert one random mid slot per bit
   task automatic send_frame(input logic [7:0] d, input logic stop, input int gmode,
                             input int stall_slot);
      exp_t e;
      logic bitv, v;
      int   gs;
      e.d  = d;
      e.fe = ~stop;
      exp_q.push_back(e);
      n_pushed++;
      for (int b = 0; b < 10; b++) begin
         if (b == 0)      bitv = 1'b0;
         else if (b == 9) bitv = stop;
         else             bitv = d[b-1];
         gs = (gmode == 2) ? int'($urandom_range(6, 4)) : 5;
         for (int s = 0; s < 8; s++) begin
            v = bitv;
            if (gmode != 0 && s == gs) v = ~v;
            drive_slot(v);
            if (b == 4 && s == 0) chk("busy_mid_frame", 32'(busy), 32'd1);
            if (b * 8 + s == stall_slot) begin
               bclk_run = 1'b0;
               repeat (500) @(posedge clk);
               #1;
               chk("stall_busy_held", 32'(busy), 32'd1);
               chk("stall_no_valid", 32'(exp_q.size()), 32'd1);
               bclk_run = 1'b1;
            end
         end
      end
   endtask

   initial begin
      rx  = 1'b1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_data", 32'(data), 32'd0);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_frame_err", 32'(frame_err), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);

      // 0xA5 at the 115200 reference rate
      idle_slots(2);
      send_frame(8'hA5, 1'b1, 0, -1);
      idle_slots(2);
      chk("busy_after_a5", 32'(busy), 32'd0);
      chk("frames_after_a5", 32'(n_valid), 32'(n_pushed));

      bper = 8;
      idle_slots(3);

      // false start: two low slots only
      drive_slot(1'b0);
      drive_slot(1'b0);
      drive_slot(1'b1);
      chk("false_start_busy", 32'(busy), 32'd1);
      idle_slots(12);
      chk("false_start_idle", 32'(busy), 32'd0);
      chk("false_start_no_valid", 32'(n_valid), 32'(n_pushed));
      chk("false_start_data_hold", 32'(data), 32'(last_exp));

      send_frame(8'h3C, 1'b0, 0, -1);
      idle_slots(3);

      send_frame(8'h00, 1'b1, 0, -1);
      send_frame(8'hFF, 1'b1, 0, -1);
      idle_slots(3);
      chk("back_to_back_count", 32'(n_valid), 32'(n_pushed));

      send_frame(8'h5A, 1'b1, 1, -1);
      idle_slots(3);

      send_frame(8'hC3, 1'b1, 0, 8 * 4 + 2);
      idle_slots(3);

      // reset in the middle of data bit 3
      for (int b = 0; b < 5; b++) begin
         for (int s = 0; s < 8; s++) begin
            if (!(b == 4 && s > 3)) drive_slot((b == 0) ? 1'b0 : 1'b0);
         end
      end
      rx  = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      last_exp = 8'h00;
      chk("midframe_rst_busy", 32'(busy), 32'd0);
      chk("midframe_rst_data", 32'(data), 32'd0);
      idle_slots(4);
      chk("midframe_rst_no_valid", 32'(n_valid), 32'(n_pushed));
      send_frame(8'h81, 1'b1, 0, -1);
      idle_slots(3);
      chk("after_rst_count", 32'(n_valid), 32'(n_pushed));

      for (int i = 0; i < 20; i++) begin
         send_frame(8'($urandom), ($urandom_range(0, 3) != 0), 2, -1);
         idle_slots(int'($urandom_range(1, 4)));
      end
      idle_slots(3);
      chk("final_data_hold", 32'(data), 32'(last_exp));

      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("frames_total", 32'(n_valid), 32'(n_pushed));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
